// File: rtl/ahb_lcd_if.sv
// AHB-Lite slave-side bus bundle for the LCD reader.
// Clock and reset stay outside the interface as plain ports.
interface ahb_lcd_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  // Address phase is accepted when HSEL & HTRANS[1] & HREADY; the data phase
  // that follows never stalls (HREADYOUT is tied high by the slave).
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_lcd_reader.sv
// AHB-Lite slave performing HD44780 4-bit read cycles (status or data RAM),
// with an optional busy-poll loop that repeats status reads until BF clears.
module ahb_lcd_reader #(
  parameter int          SETUP_CYC  = 5,
  parameter int          E_HIGH_CYC = 25,
  parameter int          E_LOW_CYC  = 25,
  parameter logic [15:0] POLL_MAX   = 16'd1000
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  ahb_lcd_if.slave   bus,
  input  logic [3:0] LCD_DATA_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_ACTIVE,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EH1   = 3'd2,
    EL1   = 3'd3,
    EH2   = 3'd4,
    EL2   = 3'd5,
    CHECK = 3'd6
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_RDATA  = 2'd2;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EH_LAST    = 16'(E_HIGH_CYC - 1);
  localparam logic [15:0] EL_LAST    = 16'(E_LOW_CYC - 1);

  // Registered AHB address phase
  logic       ph_valid_q;
  logic       ph_write_q;
  logic [1:0] ph_addr_q;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        rs_q, rs_d;
  logic        poll_q, poll_d;

  logic        busy;
  logic        ctrl_wr;
  logic        rdata_rd;
  logic        last;
  logic [15:0] cnt_inc;
  logic [31:0] hrdata;
  logic        unused_bits;

  assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:2]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_valid_q <= 1'b0;
      ph_write_q <= 1'b0;
      ph_addr_q  <= 2'd0;
    end else if (bus.HREADY) begin
      ph_valid_q <= bus.HSEL & bus.HTRANS[1];
      ph_write_q <= bus.HWRITE;
      ph_addr_q  <= bus.HADDR[3:2];
    end
  end

  assign busy     = (state_q != IDLE);
  assign ctrl_wr  = ph_valid_q & ph_write_q & (ph_addr_q == A_CTRL) & bus.HREADY;
  assign rdata_rd = ph_valid_q & ~ph_write_q & (ph_addr_q == A_RDATA) & bus.HREADY;
  assign cnt_inc  = (cnt_q < POLL_MAX) ? (cnt_q + 16'd1) : cnt_q;

  always_comb begin
    last = 1'b0;
    case (state_q)
      SETUP:    last = (timer_q == SETUP_LAST);
      EH1, EH2: last = (timer_q == EH_LAST);
      EL1, EL2: last = (timer_q == EL_LAST);
      default:  last = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      timer_q   <= 16'd0;
      shift_q   <= 8'h00;
      rdata_q   <= 8'h00;
      cnt_q     <= 16'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 16'd1;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    rs_d      = rs_q;
    poll_d    = poll_q;

    // Read-to-clear first so a CHECK completing in the same cycle wins.
    if (rdata_rd) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (ctrl_wr) begin
          poll_d    = bus.HWDATA[1];
          rs_d      = bus.HWDATA[0] & ~bus.HWDATA[1];
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = 16'd0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (last) begin
          timer_d = 16'd0;
          state_d = EH1;
        end
      end
      EH1: begin
        if (last) begin
          shift_d[7:4] = LCD_DATA_IN;
          timer_d      = 16'd0;
          state_d      = EL1;
        end
      end
      EL1: begin
        if (last) begin
          timer_d = 16'd0;
          state_d = EH2;
        end
      end
      EH2: begin
        if (last) begin
          shift_d[3:0] = LCD_DATA_IN;
          timer_d      = 16'd0;
          state_d      = EL2;
        end
      end
      EL2: begin
        if (last) begin
          timer_d = 16'd0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        timer_d = 16'd0;
        rdata_d = shift_q;
        cnt_d   = cnt_inc;
        if (poll_q && shift_q[7] && (cnt_inc < POLL_MAX)) begin
          state_d = SETUP;
        end else if (poll_q && shift_q[7]) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        timer_d = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Pins decode straight from state so an async reset drops E at once.
  assign LCD_ACTIVE  = busy;
  assign LCD_RW      = busy;
  assign LCD_RS      = busy & rs_q;
  assign LCD_E       = (state_q == EH1) || (state_q == EH2);
  assign dbg_state_o = state_q;

  always_comb begin
    hrdata = 32'd0;
    if (ph_valid_q && !ph_write_q) begin
      case (ph_addr_q)
        A_STATUS: hrdata = {29'd0, timeout_q, valid_q, busy};
        A_RDATA:  hrdata = {24'd0, (state_q == CHECK) ? shift_q : rdata_q};
        default:  hrdata = 32'd0;
      endcase
    end
  end

  assign bus.HRDATA    = hrdata;
  assign bus.HREADYOUT = 1'b1;

endmodule
